// File: rtl/pattern_buffer_loader_if.sv
// Host-side handshake bundle for pattern_buffer_loader: load request, byte stream,
// readback stream and frame/abort controls.
interface pattern_buffer_loader_if #(
    parameter int buffer_width = 8,
    parameter int addr_width   = 3
);
    logic                    load_req;
    logic [addr_width-1:0]   load_addr;
    logic                    load_ready;
    logic                    load_err;
    logic                    byte_valid;
    logic [buffer_width-1:0] byte_in;
    logic                    byte_ready;
    logic                    rb_valid;
    logic [buffer_width-1:0] rb_byte;
    logic                    abort;
    logic                    frame_sync;
    logic                    busy;

    modport master (
        output load_req, load_addr, byte_valid, byte_in, abort, frame_sync,
        input  load_ready, load_err, byte_ready, rb_valid, rb_byte, busy
    );

    modport slave (
        input  load_req, load_addr, byte_valid, byte_in, abort, frame_sync,
        output load_ready, load_err, byte_ready, rb_valid, rb_byte, busy
    );
endinterface

// File: rtl/pattern_buffer_loader.sv
// Serial-scan loader and frame-synchronous commit controller for the pattern buffer bank.
// Optional readback of displaced contents is enabled by defining BUFLOAD_READBACK_EN.
module pattern_buffer_loader #(
    parameter int buffer_size  = 22,
    parameter int buffer_width = 8,
    parameter int no_bufs      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pattern_buffer_loader_if.slave     host,
    output logic                       ssel,
    output logic [$clog2(no_bufs)-1:0] saddr,
    output logic                       sin,
    input  logic                       sout,
    output logic [no_bufs-1:0]         buffer_select
);
    localparam int addr_w = $clog2(no_bufs);
    localparam int bit_w  = $clog2(buffer_width);
    localparam int cnt_w  = $clog2(buffer_size + 1);
    localparam logic [bit_w-1:0] last_bit  = bit_w'(buffer_width - 1);
    localparam logic [cnt_w-1:0] last_byte = cnt_w'(buffer_size - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, PENDING} state_t;

    state_t                  state_q, state_d;
    logic [addr_w-1:0]       addr_q;
    logic [cnt_w-1:0]        byte_cnt_q;
    logic [bit_w-1:0]        bit_cnt_q;
    logic [buffer_width-1:0] sh_q;
    logic                    load_err_q;
    logic                    shift_in;
    logic                    accept;
    logic                    byte_done;

`ifdef BUFLOAD_READBACK_EN
    logic                    rb_valid_q;
    logic [buffer_width-1:0] rb_byte_q;

    assign shift_in      = sout;
    assign host.rb_valid = rb_valid_q;
    assign host.rb_byte  = rb_byte_q;
`else
    logic unused_sout;

    assign unused_sout   = sout;
    assign shift_in      = 1'b0;
    assign host.rb_valid = 1'b0;
    assign host.rb_byte  = '0;
`endif

    // The active buffer is the one marked in buffer_select; it may never be rewritten.
    assign accept    = (state_q == IDLE) && host.load_req && !buffer_select[host.load_addr];
    assign byte_done = (state_q == SHIFT) && (bit_cnt_q == last_bit);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = WAIT_BYTE;
            WAIT_BYTE: if (host.abort) state_d = IDLE;
                       else if (host.byte_valid) state_d = SHIFT;
            SHIFT:     if (host.abort) state_d = IDLE;
                       else if (byte_done) state_d = (byte_cnt_q == last_byte) ? PENDING : WAIT_BYTE;
            PENDING:   if (host.abort || host.frame_sync) state_d = IDLE;
        endcase
    end

    assign host.load_ready = (state_q == IDLE);
    assign host.byte_ready = (state_q == WAIT_BYTE);
    assign host.busy       = (state_q != IDLE);
    assign host.load_err   = load_err_q;
    assign ssel            = (state_q == SHIFT);
    assign sin             = ssel & sh_q[buffer_width-1];
    assign saddr           = addr_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            byte_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            sh_q          <= '0;
            load_err_q    <= 1'b0;
            buffer_select <= no_bufs'(1);
`ifdef BUFLOAD_READBACK_EN
            rb_valid_q    <= 1'b0;
            rb_byte_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            load_err_q <= (state_q == IDLE) && host.load_req && buffer_select[host.load_addr];
`ifdef BUFLOAD_READBACK_EN
            rb_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (accept) begin
                    addr_q     <= host.load_addr;
                    byte_cnt_q <= '0;
                end
                WAIT_BYTE: if (host.byte_valid && !host.abort) begin
                    sh_q      <= host.byte_in;
                    bit_cnt_q <= '0;
                end
                SHIFT: begin
                    // The bank shifts on this same edge, so sout still shows the bit leaving it.
                    sh_q      <= {sh_q[buffer_width-2:0], shift_in};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (byte_done && !host.abort) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
`ifdef BUFLOAD_READBACK_EN
                        rb_valid_q <= 1'b1;
                        rb_byte_q  <= {sh_q[buffer_width-2:0], sout};
`endif
                    end
                end
                PENDING: if (host.frame_sync && !host.abort) begin
                    buffer_select         <= '0;
                    buffer_select[addr_q] <= 1'b1;
                end
            endcase
        end
    end
endmodule
